// File: rtl/sw_debouncer_pkg.sv
// sw_pkg: shared constants and helpers for the switch debouncer slice.
//   SW_WIDTH                : number of board slide switches
//   SW_TICK_DIV_DEFAULT     : clocks per sample tick (1 ms at 100 MHz)
//   SW_STABLE_TICKS_DEFAULT : consecutive differing samples to accept a level
//   SW_TICK_DIV_SIM         : short tick period for simulation builds
//   db_action_e / db_decide : per-bit debounce decision taken on each clock
package sw_pkg;

  localparam int unsigned SW_WIDTH                = 16;
  localparam int unsigned SW_TICK_DIV_DEFAULT     = 100000;
  localparam int unsigned SW_STABLE_TICKS_DEFAULT = 10;
  localparam int unsigned SW_TICK_DIV_SIM         = 4;

  typedef enum logic [1:0] {
    DB_HOLD   = 2'd0,  // no tick: counter and level hold
    DB_CLEAR  = 2'd1,  // sample matches level: abort any pending acceptance
    DB_COUNT  = 2'd2,  // sample differs: count one more agreeing sample
    DB_ACCEPT = 2'd3   // enough differing samples: take the new level
  } db_action_e;

  function automatic db_action_e db_decide(input logic tick,
                                           input logic differs,
                                           input logic at_last);
    db_action_e act;
    if (!tick)        act = DB_HOLD;
    else if (!differs) act = DB_CLEAR;
    else if (at_last) act = DB_ACCEPT;
    else              act = DB_COUNT;
    return act;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: one switch bit's two-flop synchroniser, debounce counter,
// stable-level flop and optional edge-pulse flops.
// Optional feature macro: SW_EDGE_EN (registered rise/fall pulses; otherwise 0).
// Ports:
//   clk, rst (async, active-high)
//   tick    : shared sample strobe, one clk cycle wide
//   raw     : asynchronous bouncing pin
//   stable  : debounced level
//   rise    : one-cycle pulse when stable goes 0->1
//   fall    : one-cycle pulse when stable goes 1->0
//   accept  : combinational, high on the clock whose edge updates stable
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = SW_STABLE_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  db_action_e    act;

  always_comb begin
    act    = db_decide(tick, sync2 != stable, cnt == CNT_LAST);
    accept = (act == DB_ACCEPT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      case (act)
        DB_CLEAR:  cnt <= '0;
        DB_COUNT:  cnt <= cnt + CW'(1);
        DB_ACCEPT: begin
          cnt    <= '0;
          stable <= sync2;
        end
        default:   cnt <= cnt;
      endcase
    end
  end

`ifdef SW_EDGE_EN
  // Pulses register on the same edge as stable, so they coincide with the
  // first cycle the new level is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept & sync2;
      fall <= accept & ~sync2;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debouncer.sv
// sw_debouncer: synchronises and debounces the board slide switches into clk.
// Optional feature macro: SW_EDGE_EN (per-bit rise/fall pulses; otherwise 0).
// Ports:
//   clk, rst (async, active-high; deassertion assumed synchronous upstream)
//   sw_raw     [WIDTH] : raw bouncing switch pins
//   sw_stable  [WIDTH] : debounced level, feeds the switch peripheral sw_input
//   sw_changed         : one-cycle pulse when any sw_stable bit changes
//   sw_rise    [WIDTH] : one-cycle per-bit 0->1 pulse
//   sw_fall    [WIDTH] : one-cycle per-bit 1->0 pulse
module sw_debouncer
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH        = SW_WIDTH,
  parameter int unsigned TICK_DIV     = SW_TICK_DIV_DEFAULT,
  parameter int unsigned STABLE_TICKS = SW_STABLE_TICKS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [WIDTH-1:0] accept;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + TW'(1);
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .raw   (sw_raw[g]),
      .stable(sw_stable[g]),
      .rise  (sw_rise[g]),
      .fall  (sw_fall[g]),
      .accept(accept[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sw_changed <= 1'b0;
    else     sw_changed <= |accept;
  end

endmodule

// File: tb/tb_sw_debouncer.sv
module tb_sw_debouncer;

  localparam int TDIV = 4;
  localparam int STK  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw_raw = '0;
  logic [15:0] sw_stable;
  logic        sw_changed;
  logic [15:0] sw_rise;
  logic [15:0] sw_fall;

  int errors = 0;
  int checks = 0;

  sw_debouncer #(
    .WIDTH(16),
    .TICK_DIV(TDIV),
    .STABLE_TICKS(STK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw_stable(sw_stable),
    .sw_changed(sw_changed),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );

  always #5 clk = ~clk;

  // Reference model: counts clock edges since reset release, keeps the raw
  // history, and applies the debounce rule to the sample two edges old on
  // every edge whose index is TDIV-1 modulo TDIV.
  logic [15:0] rawhist[$];
  int          ecount;
  int          run[16];
  logic [15:0] m_stable, m_rise, m_fall;
  logic        m_changed;

  task automatic model_reset();
    rawhist.delete();
    ecount = 0;
    for (int i = 0; i < 16; i++) run[i] = 0;
    m_stable = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0;
  endtask

  task automatic model_edge(input logic [15:0] r);
    logic [15:0] samp;
    samp = (ecount >= 2) ? rawhist[ecount-2] : 16'h0000;
    rawhist.push_back(r);
    m_rise = '0; m_fall = '0; m_changed = 1'b0;
    if ((ecount % TDIV) == TDIV - 1) begin
      for (int i = 0; i < 16; i++) begin
        if (samp[i] != m_stable[i]) begin
          run[i]++;
          if (run[i] == STK) begin
            run[i] = 0;
            m_stable[i] = samp[i];
            m_changed = 1'b1;
`ifdef SW_EDGE_EN
            if (samp[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
`endif
          end
        end else begin
          run[i] = 0;
        end
      end
    end
    ecount++;
  endtask

  // One clock: drive raw just after the falling edge, step the model on the
  // rising edge, compare all outputs at the next falling edge.
  task automatic cyc(input logic [15:0] r);
    sw_raw = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    checks++;
    if (sw_stable !== m_stable) begin
      errors++;
      $display("FAIL stable t=%0t got=%h exp=%h", $time, sw_stable, m_stable);
    end
    checks++;
    if (sw_changed !== m_changed) begin
      errors++;
      $display("FAIL changed t=%0t got=%b exp=%b", $time, sw_changed, m_changed);
    end
    checks++;
    if (sw_rise !== m_rise) begin
      errors++;
      $display("FAIL rise t=%0t got=%h exp=%h", $time, sw_rise, m_rise);
    end
    checks++;
    if (sw_fall !== m_fall) begin
      errors++;
      $display("FAIL fall t=%0t got=%h exp=%h", $time, sw_fall, m_fall);
    end
  endtask

  task automatic assert_reset(input string name);
    rst = 1'b1;
    #1;
    checks++;
    if ({sw_stable, sw_changed, sw_rise, sw_fall} !== '0) begin
      errors++;
      $display("FAIL %s_zero got stable=%h chg=%b rise=%h fall=%h exp=all 0",
               name, sw_stable, sw_changed, sw_rise, sw_fall);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({sw_stable, sw_changed, sw_rise, sw_fall} !== '0) begin
      errors++;
      $display("FAIL %s_hold got stable=%h chg=%b exp=all 0", name, sw_stable, sw_changed);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    int rise_seen, first_ok;
    sw_raw = 16'hFFFF;
    @(negedge clk);
    assert_reset("reset");
    rise_seen = 0; first_ok = -1;
    for (int c = 1; c <= 20; c++) begin
      cyc(16'hFFFF);
      if (sw_rise === 16'hFFFF && sw_changed === 1'b1) rise_seen++;
      if (first_ok < 0 && sw_stable === 16'hFFFF) first_ok = c;
    end
    checks++;
    if (first_ok < 0 || first_ok > 15) begin
      errors++;
      $display("FAIL reset_latency got=%0d exp<=15", first_ok);
    end
`ifdef SW_EDGE_EN
    checks++;
    if (rise_seen != 1) begin
      errors++;
      $display("FAIL reset_rise_pulses got=%0d exp=1", rise_seen);
    end
`endif
  endtask

  task automatic test_single_bit();
    repeat (16) cyc(16'h0000);
    repeat (20) cyc(16'h0008);
    checks++;
    if (sw_stable !== 16'h0008) begin
      errors++;
      $display("FAIL single_bit got=%h exp=0008", sw_stable);
    end
  endtask

  task automatic test_bounce();
    int chg;
    logic [15:0] r;
    r = 16'h0008;
    chg = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 5 == 0) r[0] = ~r[0];
      cyc(r);
      if (sw_changed === 1'b1) chg++;
    end
    checks++;
    if (chg != 0) begin
      errors++;
      $display("FAIL bounce_quiet got=%0d changes exp=0", chg);
    end
    chg = 0;
    for (int c = 0; c < 24; c++) begin
      cyc(16'h0009);
      if (sw_changed === 1'b1) chg++;
    end
    checks++;
    if (chg != 1 || sw_stable !== 16'h0009) begin
      errors++;
      $display("FAIL bounce_settle got=%0d changes stable=%h exp=1 changes 0009", chg, sw_stable);
    end
  endtask

  task automatic test_simultaneous();
    int hits;
    repeat (20) cyc(16'h00F0);
    hits = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(16'h0F00);
      if (sw_changed === 1'b1) begin
        hits++;
        checks++;
        if (sw_stable !== 16'h0F00) begin
          errors++;
          $display("FAIL simul_stable got=%h exp=0F00", sw_stable);
        end
`ifdef SW_EDGE_EN
        checks++;
        if (sw_rise !== 16'h0F00 || sw_fall !== 16'h00F0) begin
          errors++;
          $display("FAIL simul_edges got rise=%h fall=%h exp rise=0F00 fall=00F0", sw_rise, sw_fall);
        end
`else
        checks++;
        if (sw_rise !== 16'h0000 || sw_fall !== 16'h0000) begin
          errors++;
          $display("FAIL simul_edges_off got rise=%h fall=%h exp=0", sw_rise, sw_fall);
        end
`endif
      end
    end
    checks++;
    if (hits != 1) begin
      errors++;
      $display("FAIL simul_updates got=%0d exp=1", hits);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (run[5] != 2 && guard < 40) begin
      cyc(16'h0F20);
      guard++;
    end
    checks++;
    if (run[5] != 2) begin
      errors++;
      $display("FAIL midreset_setup got run=%0d exp=2", run[5]);
    end
    assert_reset("midreset");
    for (int c = 1; c <= 12; c++) begin
      cyc(16'h0F20);
      if (c == 11) begin
        checks++;
        if (sw_stable[5] !== 1'b0) begin
          errors++;
          $display("FAIL midreset_early got=%b exp=0", sw_stable[5]);
        end
      end
    end
    checks++;
    if (sw_stable !== 16'h0F20) begin
      errors++;
      $display("FAIL midreset_done got=%h exp=0F20", sw_stable);
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    int hold;
    r = sw_raw;
    for (int n = 0; n < 60; n++) begin
      r = r ^ 16'($urandom);
      hold = $urandom_range(1, 18);
      for (int c = 0; c < hold; c++) cyc(r);
    end
    repeat (16) cyc(r);
    checks++;
    if (sw_stable !== r) begin
      errors++;
      $display("FAIL random_final got=%h exp=%h", sw_stable, r);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_bit();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
